adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
- Downstream consumer of the per-channel ADC deserialiser.
- Takes a deserialised sample plus its one-cycle completion strobe, already in the system clock domain.
- Waits for an arm and then a trigger, captures a fixed-length window of samples, and packs sample pairs into 32-bit words.
- Streams the words out over a valid/ready interface toward the DMA/readout path.

Parameters:
- DATA_WIDTH, 12, sample width in bits; must be ≤16.
- CAPTURE_LEN, 1024, samples per capture; must be even and ≥2.
- FIFO_DEPTH, 16, output word FIFO depth; must be a power of 2.

Ports:
- clk  in  1  system/sampling clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  DATA_WIDTH  deserialised sample; valid only when sample_valid=1.
- sample_valid  in  1  one-cycle strobe per completed sample.
- arm  in  1  level, sampled each cycle; starts a capture sequence from IDLE.
- trig_ext  in  1  external trigger, level-sensitive.
- trig_self_en  in  1  enables the threshold self-trigger.
- trig_threshold  in  DATA_WIDTH  unsigned self-trigger level.
- m_tdata  out  32  packed output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  marks the final word of a capture.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at capture completion.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, overflow=0. Reset also empties the FIFO, clears the sample counter and pack register, and puts the FSM in IDLE. Reset asserted mid-capture abandons the capture with no done pulse.
- IDLE:
  - arm=1 → go to ARMED next cycle and clear overflow.
  - Trigger conditions are ignored in IDLE.
  - If arm and a trigger condition occur in the same cycle, only the arm takes effect; the trigger is evaluated from the following cycle.
- ARMED:
  - Transition to CAPTURE requires a cycle with sample_valid=1 AND at least one of:
    - trig_ext=1;
    - trig_self_en=1 AND sample_in ≥ trig_threshold (unsigned compare).
  - The sample in the triggering cycle is capture sample 0.
  - trig_ext high without sample_valid keeps the FSM in ARMED.
- CAPTURE:
  - Every sample_valid sample is captured; the counter runs 0..CAPTURE_LEN-1.
  - Even-index sample → pack register low half.
  - Odd-index sample completes the word: m_tdata[15:0] = zero-extended even sample, m_tdata[31:16] = zero-extended odd sample. The word is pushed into the FIFO in the same cycle the odd sample arrives, so data appears at the FIFO output 1 cycle later.
  - The word holding sample CAPTURE_LEN-1 carries last=1. After pushing it, go to FLUSH.
- FLUSH: wait until the FIFO is empty (final word accepted), then go to IDLE with done=1 for exactly one cycle.
- arm is ignored outside IDLE; trigger inputs are ignored outside ARMED.
- Full FIFO:
  - A push attempted while the FIFO is full drops the word and sets overflow.
  - The sample counter still advances.
  - If the dropped word is the last word, no m_tlast is emitted for that capture; done still pulses after drain.
- Simultaneous push and pop while full: the pop frees space first, so the push succeeds.
- Output follows AXI-Stream rules:
  - m_tdata/m_tlast hold stable while m_tvalid=1 and m_tready=0.
  - A transfer happens when m_tvalid & m_tready.
- Counter widths are $clog2(CAPTURE_LEN) bits; there is no wrap inside a capture.

Optional Feature:
- Macro: ADC_CAPTURE_HEADER_EN.
- When defined:
  - On entering CAPTURE, one header word {16'hA5C0, seq[15:0]} is pushed before the data words.
  - seq is a 16-bit capture counter, reset to 0, incremented on each done pulse, wrapping 0xFFFF→0x0000.
  - A dropped header word sets overflow, like any other drop.
- When undefined: no header word, no seq register; the output carries data words only.

Decomposition:
- Package adc_capture_pkg holds:
  - the FSM state enum (IDLE, ARMED, CAPTURE, FLUSH);
  - the HEADER_MAGIC constant 16'hA5C0;
  - a pack function (two samples → 32-bit word).
- Sub-module adc_capture_fifo:
  - synchronous FIFO, width 33 bits (data + last), depth FIFO_DEPTH;
  - first-word-fall-through, with full/empty flags;
  - same clk and rst.

Test Plan:
- CAPTURE_LEN=4, arm, then trig_ext=1 with samples 0x001,0x002,0x003,0x004 and m_tready=1 → words 0x00020001, then 0x00040003 with m_tlast=1; done pulses once; busy returns to 0.
- trig_self_en=1, threshold=0x800, samples 0x7FF then 0x800 → capture starts at 0x800 (word[15:0]=0x0800); the 0x7FF sample is not captured.
- m_tready=0 for the whole capture, CAPTURE_LEN=64, FIFO_DEPTH=16 → 16 words held; overflow=1; the first word is unchanged after release; no m_tlast; done pulses after drain.
- arm and trig_ext asserted in the same IDLE cycle with sample_valid → FSM is in ARMED (not CAPTURE) on the next cycle; the capture starts at the next valid sample.
- rst asserted in the middle of CAPTURE → m_tvalid=0, busy=0, FIFO empty, no done pulse; a fresh arm/trigger then works normally.
- With ADC_CAPTURE_HEADER_EN, two back-to-back captures → first words are 0xA5C00000 and 0xA5C00001.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture controller.
// Optional header word support is controlled by ADC_CAPTURE_HEADER_EN in the top.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } cap_state_e;

    localparam logic [15:0] HEADER_MAGIC = 16'hA5C0;

    // Even-index sample sits in the low half, odd-index sample in the high half.
    function automatic logic [31:0] pack_pair(input logic [15:0] even_s, input logic [15:0] odd_s);
        return {odd_s, even_s};
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
// A pop in the same cycle as a push frees space first, so a push into a full FIFO succeeds then.
module adc_capture_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_FULL);
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; the flags alone decide what is readable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Arm/trigger capture controller: packs sample pairs into 32-bit words and streams them out.
// Define ADC_CAPTURE_HEADER_EN to prefix each capture with a {16'hA5C0, seq} header word.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int CAPTURE_LEN = 1024,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  trig_ext,
    input  logic                  trig_self_en,
    input  logic [DATA_WIDTH-1:0] trig_threshold,
    output logic [31:0]           m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            state_o
);

    localparam int CW = $clog2(CAPTURE_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(CAPTURE_LEN - 1);
    localparam logic [CW-1:0] ONE_IDX  = CW'(1);

    cap_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [15:0]    pack_q;
    logic           busy_q;
    logic           done_q;
    logic           overflow_q;
`ifdef ADC_CAPTURE_HEADER_EN
    logic [15:0]    seq_q;
`endif

    logic [15:0]    sample_ext;
    logic           trig_hit;
    logic           push_req;
    logic [32:0]    push_data;
    logic [32:0]    fifo_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           drop;

    assign sample_ext = 16'(sample_in);
    assign trig_hit   = sample_valid && (trig_ext || (trig_self_en && (sample_in >= trig_threshold)));

    // Output handshake: a word transfers on any cycle with m_tvalid && m_tready; while
    // m_tvalid is high and m_tready low the FIFO head, and thus m_tdata/m_tlast, stays put.
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_data[31:0] : 32'd0;
    assign m_tlast  = m_tvalid & fifo_data[32];
    assign pop      = m_tvalid & m_tready;
    assign drop     = push_req && fifo_full && !pop;

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign state_o  = state_q;

    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        case (state_q)
            ARMED: begin
`ifdef ADC_CAPTURE_HEADER_EN
                if (trig_hit) begin
                    push_req  = 1'b1;
                    push_data = {1'b0, HEADER_MAGIC, seq_q};
                end
`endif
            end
            CAPTURE: begin
                if (sample_valid && cnt_q[0]) begin
                    push_req  = 1'b1;
                    push_data = {(cnt_q == LAST_IDX), pack_pair(pack_q, sample_ext)};
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pack_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
            seq_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q    <= ARMED;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        state_q <= CAPTURE;
                        pack_q  <= sample_ext;
                        cnt_q   <= ONE_IDX;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        if (!cnt_q[0]) begin
                            pack_q <= sample_ext;
                        end
                        if (cnt_q == LAST_IDX) begin
                            state_q <= FLUSH;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef ADC_CAPTURE_HEADER_EN
                        seq_q   <= seq_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    adc_capture_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule
